regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//  Parametrised successor of the CPU register file: DEPTH x DATA_W registers, NUM_RD registered read ports.
//  Adds write-to-read forwarding, optional hardwired-zero R0 and a memory-mapped switch input register.
//  Adds a button-stepped debug display channel driving the 16-bit LED/7-seg bus.
//  Sits between decode (SR/DR) and writeback (Reg_In/RegW) in the datapath.
// PARAMETERS
//  DATA_W    32  register width; must be >= 16
//  ADDR_W    5   register index width; DEPTH = 2**ADDR_W
//  NUM_RD    2   number of read ports
//  ZERO_R0   1   1: R0 reads 0 and ignores writes
//  SW_REG    1   index of the switch-input register
//  SW_W      3   switch count; SW_W < DATA_W
//  DISP_RST  2   register shown on display after reset
// PORTS
//  CLK      in   1              clock, all state updates on posedge
//  RST      in   1              synchronous reset, active-high
//  RegW     in   1              write enable
//  DR       in   ADDR_W         write index
//  Reg_In   in   DATA_W         write data
//  SR       in   NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
//  ReadReg  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//  SW       in   SW_W           board switches
//  btnL     in   1              display step button (level, pre-debounced)
//  btnR     in   1              display half select: 1 = upper 16 bits
//  disp_idx out  ADDR_W         register currently displayed
//  readreg  out  16             display bus
// BEHAVIOUR
//  Reset (RST=1 at posedge): all registers 0, ReadReg 0, display 0, disp_idx=DISP_RST, btnL_q=1. RST beats every other event.
//  Write: at posedge, REG[DR] <= Reg_In iff RegW and DR!=SW_REG and !(ZERO_R0 && DR==0). Other writes are dropped silently.
//  Switch reg: each non-reset posedge, REG[SW_REG] <= zero-extended SW. A write to SW_REG never lands.
//  Reads: 1-cycle latency. ReadReg[k] <= fwd ? Reg_In : REG[SR[k]].
//    fwd = a write that lands this same edge with DR==SR[k] (write-first).
//    A read of SW_REG returns the SW value sampled one edge earlier.
//    R0 with ZERO_R0=1 always returns 0.
//  Display: display <= REG[disp_idx] every posedge, no forwarding, so it lags one cycle.
//    readreg is combinational: btnR ? display[DATA_W-1 -: 16] : display[15:0].
//  Stepping: btnL_q <= btnL; rise = btnL & ~btnL_q. On rise, disp_idx <= disp_idx+1, wrapping DEPTH-1 -> 0.
//    One step per press; a held button gives no repeat.
//    btnL_q resets to 1, so a button held through reset does not step.
//    display follows the new index one cycle after the step.
//  All ports are independent; any combination of SR values, duplicates included, is legal in the same cycle.
// STRUCTURE
//  Shared package/header regfile_pkg: ADDR_W, DATA_W, ZERO_R0, SW_REG defaults, plus the
//  function for packed-port slicing. The decode stage uses the same constants.
//  One sub-module, btn_rise (1-bit synchronous rising-edge detector with reset value
//  parameter), instantiated for btnL.
//  Storage: reg array, with a generate loop over NUM_RD read ports.
// TESTING
//  1 RST high 2 cycles -> ReadReg=0, readreg=0, disp_idx=2; all reads of R0..R31 return 0.
//  2 RegW=1 DR=5 Reg_In=32'hDEADBEEF, SR0=5 same cycle -> ReadReg0=DEADBEEF at the next edge (forward).
//    Next cycle, SR1=5 -> DEADBEEF.
//  3 RegW=1 DR=0 Reg_In=32'h1234 -> R0 reads 0.
//    RegW=1 DR=1 Reg_In=FFFF with SW=3'b101 -> R1 reads 32'h5.
//  4 Write R2=32'hCAFE_F00D -> after 2 cycles readreg=F00D; btnR=1 -> CAFE.
//  5 btnL pulses 30 times from idx 2 -> disp_idx=0 (wrap).
//    btnL held 10 cycles -> exactly one step. btnL held across RST -> idx stays 2.
//  6 NUM_RD=3 DATA_W=16 build: three ports reading the same reg return identical data.
//    btnR does not change readreg.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and packed-port slicing helper
package regfile_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int ZERO_R0_DEF = 1;
    localparam int SW_REG_DEF  = 1;

    // LSB position of port `port` inside a packed bus of `width`-bit lanes.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/btn_rise.sv
// rtl/btn_rise.sv - 1-bit synchronous rising-edge detector with configurable reset value
module btn_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with forwarding, switch register and debug display
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = ZERO_R0_DEF,
    parameter int SW_REG   = SW_REG_DEF,
    parameter int SW_W     = 3,
    parameter int DISP_RST = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RegW,
    input  logic [ADDR_W-1:0]        DR,
    input  logic [DATA_W-1:0]        Reg_In,
    input  logic [NUM_RD*ADDR_W-1:0] SR,
    output logic [NUM_RD*DATA_W-1:0] ReadReg,
    input  logic [SW_W-1:0]          SW,
    input  logic                     btnL,
    input  logic                     btnR,
    output logic [ADDR_W-1:0]        disp_idx,
    output logic [15:0]              readreg
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SW_IDX = ADDR_W'(SW_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] display;
    logic              wr_lands;
    logic              step;

    // The switch register and a hardwired R0 are owned by the file itself, so writeback cannot touch them.
    assign wr_lands = RegW && (DR != SW_IDX) && !((ZERO_R0 != 0) && (DR == '0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_lands) begin
                regs[DR] <= Reg_In;
            end
            regs[SW_IDX] <= DATA_W'(SW);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] sr_k;
        logic [DATA_W-1:0] rd_q;

        assign sr_k = SR[port_lsb(k, ADDR_W) +: ADDR_W];

        // Write-first: a write landing on the read index this edge is returned directly.
        always_ff @(posedge CLK) begin
            if (RST) begin
                rd_q <= '0;
            end else if (wr_lands && (DR == sr_k)) begin
                rd_q <= Reg_In;
            end else begin
                rd_q <= regs[sr_k];
            end
        end

        assign ReadReg[port_lsb(k, DATA_W) +: DATA_W] = rd_q;
    end

    btn_rise #(
        .RST_VAL(1'b1)
    ) u_btn_l (
        .CLK (CLK),
        .RST (RST),
        .d   (btnL),
        .rise(step)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_idx <= ADDR_W'(DISP_RST);
            display  <= '0;
        end else begin
            if (step) begin
                disp_idx <= disp_idx + ADDR_W'(1);
            end
            display <= regs[disp_idx];
        end
    end

    assign readreg = btnR ? display[DATA_W-1 -: 16] : display[15:0];

endmodule
